// File: rtl/cpu_phase_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : cpu_phase_sequencer
// Brief    : Multi-cycle CPU phase sequencer with memory wait, stall,
//            halt/resume and sticky memory-timeout fault.
// Revision : 1.0
// ============================================================================
module cpu_phase_sequencer #(
    parameter int                    NUM_PHASES     = 4,
    parameter logic [NUM_PHASES-1:0] MEM_PHASE_MASK = NUM_PHASES'(4'b1001),
    parameter int                    WAIT_MAX       = 15,
    parameter int                    CNT_W          = 16,
    localparam int                   PHASE_W        = $clog2(NUM_PHASES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  stall,
    input  logic                  mem_ready,
    input  logic                  halt_req,
    input  logic                  resume,
    output logic [PHASE_W-1:0]    phase,
    output logic [NUM_PHASES-1:0] phase_onehot,
    output logic                  phase_first,
    output logic                  mem_req,
    output logic                  pc_inc,
    output logic [CNT_W-1:0]      retired,
    output logic                  halted,
    output logic                  fault
);

    localparam int WAIT_W    = $clog2(WAIT_MAX + 1);
    localparam int c_PH_SPAN = 1 << PHASE_W;

    localparam logic [1:0] c_RUN    = 2'd0;
    localparam logic [1:0] c_HALTED = 2'd1;
    localparam logic [1:0] c_FAULT  = 2'd2;

    localparam logic [PHASE_W-1:0]    c_LAST        = PHASE_W'(NUM_PHASES - 1);
    localparam logic [WAIT_W-1:0]     c_WAIT_MAX    = WAIT_W'(WAIT_MAX);
    localparam logic [NUM_PHASES-1:0] c_ONEHOT_LAST = NUM_PHASES'(1) << (NUM_PHASES - 1);

    logic [1:0]            r_state;
    logic [PHASE_W-1:0]    r_phase;
    logic                  r_boot;
    logic [WAIT_W-1:0]     r_wait;
    logic [CNT_W-1:0]      r_retired;
    logic                  r_first;
    logic [NUM_PHASES-1:0] r_onehot;

    logic [c_PH_SPAN-1:0]  w_mask_ext;
    logic                  w_run;
    logic                  w_mem_phase;
    logic                  w_adv;
    logic                  w_mem_req;
    logic                  w_pc_inc;
    logic                  w_wait_cnt;
    logic [1:0]            w_state_nxt;
    logic [PHASE_W-1:0]    w_phase_nxt;
    logic                  w_boot_nxt;
    logic [WAIT_W-1:0]     w_wait_nxt;
    logic                  w_first_nxt;
    logic [NUM_PHASES-1:0] w_onehot_nxt;

    // Padded so any encodable phase value indexes a defined bit.
    assign w_mask_ext  = c_PH_SPAN'(MEM_PHASE_MASK);
    assign w_run       = (r_state == c_RUN);
    assign w_mem_phase = w_mask_ext[r_phase];
    assign w_adv       = w_run && !stall && (r_boot || !w_mem_phase || mem_ready);
    assign w_mem_req   = w_run && !r_boot && w_mem_phase;
    assign w_pc_inc    = w_adv && (r_phase == c_LAST);
    assign w_wait_cnt  = w_mem_req && !mem_ready && !stall;

    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        w_boot_nxt  = r_boot;
        w_wait_nxt  = r_wait;
        w_first_nxt = 1'b0;
        case (r_state)
            c_RUN: begin
                if (w_wait_cnt) begin
                    if (r_wait == c_WAIT_MAX) begin
                        w_state_nxt = c_FAULT;
                    end else begin
                        w_wait_nxt = r_wait + 1'b1;
                    end
                end
                if (w_adv) begin
                    w_wait_nxt  = '0;
                    w_first_nxt = 1'b1;
                    if (r_phase == c_LAST) begin
                        w_boot_nxt = 1'b0;
                        // Halt is only taken at an instruction boundary.
                        if (halt_req) begin
                            w_state_nxt = c_HALTED;
                            w_first_nxt = 1'b0;
                        end else begin
                            w_phase_nxt = '0;
                        end
                    end else begin
                        w_phase_nxt = r_phase + 1'b1;
                    end
                end
            end
            c_HALTED: begin
                if (resume) begin
                    w_state_nxt = c_RUN;
                    w_phase_nxt = '0;
                    w_wait_nxt  = '0;
                    w_first_nxt = 1'b1;
                end
            end
            default: begin
                w_state_nxt = r_state;
            end
        endcase
        w_onehot_nxt = (w_state_nxt == c_RUN) ? (NUM_PHASES'(1) << w_phase_nxt) : '0;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= c_RUN;
            r_phase   <= c_LAST;
            r_boot    <= 1'b1;
            r_wait    <= '0;
            r_retired <= '0;
            r_first   <= 1'b1;
            r_onehot  <= c_ONEHOT_LAST;
        end else begin
            r_state  <= w_state_nxt;
            r_phase  <= w_phase_nxt;
            r_boot   <= w_boot_nxt;
            r_wait   <= w_wait_nxt;
            r_first  <= w_first_nxt;
            r_onehot <= w_onehot_nxt;
            if (w_pc_inc && !r_boot) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign phase        = r_phase;
    assign phase_onehot = r_onehot;
    assign phase_first  = r_first;
    assign mem_req      = w_mem_req;
    assign pc_inc       = w_pc_inc;
    assign retired      = r_retired;
    assign halted       = (r_state == c_HALTED);
    assign fault        = (r_state == c_FAULT);

endmodule
`default_nettype wire

// File: tb/tb_cpu_phase_sequencer.sv
`default_nettype none
// Bench for cpu_phase_sequencer: default and 6-phase instances share stimulus
// and are checked every cycle against an abstract per-instance model.
module tb_cpu_phase_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1, stall = 1'b0, mem_ready = 1'b0, halt_req = 1'b0, resume = 1'b0;

    logic [1:0]  p0_phase;  logic [3:0] p0_onehot; logic p0_first, p0_mreq, p0_pcinc;
    logic [15:0] p0_ret;    logic p0_halted, p0_fault;
    logic [2:0]  p1_phase;  logic [5:0] p1_onehot; logic p1_first, p1_mreq, p1_pcinc;
    logic [1:0]  p1_ret;    logic p1_halted, p1_fault;

    cpu_phase_sequencer dut0 (
        .clk(clk), .reset(reset), .stall(stall), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume),
        .phase(p0_phase), .phase_onehot(p0_onehot), .phase_first(p0_first),
        .mem_req(p0_mreq), .pc_inc(p0_pcinc), .retired(p0_ret),
        .halted(p0_halted), .fault(p0_fault)
    );

    cpu_phase_sequencer #(
        .NUM_PHASES(6), .MEM_PHASE_MASK(6'b100001), .WAIT_MAX(3), .CNT_W(2)
    ) dut1 (
        .clk(clk), .reset(reset), .stall(stall), .mem_ready(mem_ready),
        .halt_req(halt_req), .resume(resume),
        .phase(p1_phase), .phase_onehot(p1_onehot), .phase_first(p1_first),
        .mem_req(p1_mreq), .pc_inc(p1_pcinc), .retired(p1_ret),
        .halted(p1_halted), .fault(p1_fault)
    );

    int vectors = 0;
    int miscompares = 0;
    bit check_en = 1'b0;

    // ---------------- abstract model ----------------
    localparam int M_RUN = 0, M_HALT = 1, M_FLT = 2;
    int cfg_n[2]    = '{4, 6};
    int cfg_mask[2] = '{9, 33};
    int cfg_wm[2]   = '{15, 3};
    int cfg_cw[2]   = '{16, 2};

    int m_mode[2]  = '{0, 0};
    int m_ph[2]    = '{0, 0};
    int m_wait[2]  = '{0, 0};
    int m_ret[2]   = '{0, 0};
    bit m_boot[2]  = '{1'b1, 1'b1};
    bit m_first[2] = '{1'b0, 1'b0};

    function automatic bit f_memph(int i);
        return ((cfg_mask[i] >> m_ph[i]) & 1) != 0;
    endfunction
    function automatic bit f_mreq(int i);
        return m_mode[i] == M_RUN && !m_boot[i] && f_memph(i);
    endfunction
    function automatic bit f_adv(int i);
        return m_mode[i] == M_RUN && !stall && (m_boot[i] || !f_memph(i) || mem_ready);
    endfunction
    function automatic bit f_pcinc(int i);
        return f_adv(i) && m_ph[i] == cfg_n[i] - 1;
    endfunction

    task automatic model_step(input int i);
        bit adv, pc, mreq;
        adv  = f_adv(i);
        pc   = f_pcinc(i);
        mreq = f_mreq(i);
        if (!reset) begin
            m_mode[i] = M_RUN; m_ph[i] = cfg_n[i] - 1; m_boot[i] = 1'b1;
            m_wait[i] = 0; m_ret[i] = 0; m_first[i] = 1'b1;
        end else if (m_mode[i] == M_RUN) begin
            m_first[i] = 1'b0;
            if (mreq && !mem_ready && !stall) begin
                if (m_wait[i] == cfg_wm[i]) m_mode[i] = M_FLT;
                else m_wait[i]++;
            end
            if (adv) begin
                m_wait[i] = 0;
                m_first[i] = 1'b1;
                if (pc) begin
                    if (!m_boot[i]) m_ret[i] = (m_ret[i] + 1) % (1 << cfg_cw[i]);
                    m_boot[i] = 1'b0;
                    if (halt_req) begin
                        m_mode[i] = M_HALT;
                        m_first[i] = 1'b0;
                    end else begin
                        m_ph[i] = 0;
                    end
                end else begin
                    m_ph[i]++;
                end
            end
        end else if (m_mode[i] == M_HALT) begin
            m_first[i] = 1'b0;
            if (resume) begin
                m_mode[i] = M_RUN; m_ph[i] = 0; m_wait[i] = 0; m_first[i] = 1'b1;
            end
        end else begin
            m_first[i] = 1'b0;
        end
    endtask

    always @(posedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] f_onehot(int i);
        return (m_mode[i] == M_RUN) ? (32'd1 << m_ph[i]) : 32'd0;
    endfunction

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (check_en) begin
            chk("d0.phase",   32'(p0_phase),  32'(m_ph[0]));
            chk("d0.onehot",  32'(p0_onehot), f_onehot(0));
            if (m_mode[0] == M_RUN) chk("d0.first", 32'(p0_first), 32'(m_first[0]));
            chk("d0.mem_req", 32'(p0_mreq),   32'(f_mreq(0)));
            chk("d0.pc_inc",  32'(p0_pcinc),  32'(f_pcinc(0)));
            chk("d0.retired", 32'(p0_ret),    32'(m_ret[0]));
            chk("d0.halted",  32'(p0_halted), 32'(m_mode[0] == M_HALT));
            chk("d0.fault",   32'(p0_fault),  32'(m_mode[0] == M_FLT));
            chk("d1.phase",   32'(p1_phase),  32'(m_ph[1]));
            chk("d1.onehot",  32'(p1_onehot), f_onehot(1));
            if (m_mode[1] == M_RUN) chk("d1.first", 32'(p1_first), 32'(m_first[1]));
            chk("d1.mem_req", 32'(p1_mreq),   32'(f_mreq(1)));
            chk("d1.pc_inc",  32'(p1_pcinc),  32'(f_pcinc(1)));
            chk("d1.retired", 32'(p1_ret),    32'(m_ret[1]));
            chk("d1.halted",  32'(p1_halted), 32'(m_mode[1] == M_HALT));
            chk("d1.fault",   32'(p1_fault),  32'(m_mode[1] == M_FLT));
        end
    end

    // Inputs change 1 time unit after a rising edge; literal checks run just
    // after the following falling edge, before the next rising edge.
    task automatic tick(input bit r, input bit s, input bit mr, input bit hr, input bit rs);
        @(posedge clk);
        #1;
        reset = r; stall = s; mem_ready = mr; halt_req = hr; resume = rs;
        @(negedge clk);
        #1;
    endtask

    initial begin
        int pct;
        int pcts[3] = '{90, 50, 5};

        tick(0, 0, 1, 0, 0);
        tick(0, 0, 1, 0, 0);
        check_en = 1'b1;
        chk("lit.rst_phase",   32'(p0_phase),  32'd3);
        chk("lit.rst_first",   32'(p0_first),  32'd1);
        chk("lit.rst_retired", 32'(p0_ret),    32'd0);
        chk("lit.rst_onehot",  32'(p0_onehot), 32'b1000);
        chk("lit.rst_fault",   32'(p0_fault),  32'd0);

        tick(1, 0, 0, 0, 0);
        chk("lit.boot_pcinc",  32'(p0_pcinc),  32'd1);
        chk("lit.boot_memreq", 32'(p0_mreq),   32'd0);

        for (int k = 0; k < 3; k++) begin
            tick(1, 0, 0, 0, 0);
            chk("lit.fetch_phase",  32'(p0_phase), 32'd0);
            chk("lit.fetch_memreq", 32'(p0_mreq),  32'd1);
            chk("lit.fetch_first",  32'(p0_first), (k == 0) ? 32'd1 : 32'd0);
        end
        tick(1, 0, 1, 0, 0);
        chk("lit.fetch_last", 32'(p0_phase), 32'd0);
        tick(1, 0, 1, 0, 0);
        chk("lit.decode", 32'(p0_phase), 32'd1);

        for (int k = 0; k < 5; k++) begin
            tick(1, 1, 1, 0, 0);
            chk("lit.stall_phase", 32'(p0_phase), 32'd2);
            chk("lit.stall_pcinc", 32'(p0_pcinc), 32'd0);
        end
        tick(1, 0, 1, 0, 0);
        chk("lit.exec_resumed", 32'(p0_phase), 32'd2);
        tick(1, 0, 1, 1, 0);
        chk("lit.store_pcinc", 32'(p0_pcinc), 32'd1);
        chk("lit.store_ret",   32'(p0_ret),   32'd0);
        tick(1, 0, 1, 0, 0);
        chk("lit.halted",      32'(p0_halted), 32'd1);
        chk("lit.halt_memreq", 32'(p0_mreq),   32'd0);
        chk("lit.halt_ret",    32'(p0_ret),    32'd1);
        chk("lit.halt_onehot", 32'(p0_onehot), 32'd0);
        tick(1, 0, 1, 0, 1);
        tick(1, 0, 1, 0, 0);
        chk("lit.resume_phase", 32'(p0_phase),  32'd0);
        chk("lit.resume_first", 32'(p0_first),  32'd1);
        chk("lit.resume_halt",  32'(p0_halted), 32'd0);
        tick(1, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0);

        for (int k = 1; k <= 16; k++) begin
            tick(1, 0, 0, 0, 0);
            chk("lit.wait_fault", 32'(p0_fault), 32'd0);
        end
        tick(1, 0, 0, 0, 0);
        chk("lit.fault",        32'(p0_fault),  32'd1);
        chk("lit.fault_onehot", 32'(p0_onehot), 32'd0);
        chk("lit.fault_phase",  32'(p0_phase),  32'd3);
        chk("lit.fault_memreq", 32'(p0_mreq),   32'd0);
        tick(1, 0, 1, 0, 0);
        chk("lit.fault_sticky", 32'(p0_fault),  32'd1);
        tick(0, 0, 1, 0, 0);
        tick(1, 0, 1, 0, 0);
        chk("lit.clr_fault", 32'(p0_fault), 32'd0);
        chk("lit.clr_phase", 32'(p0_phase), 32'd3);

        for (int blk = 0; blk < 15; blk++) begin
            pct = pcts[blk % 3];
            for (int c = 0; c < 200; c++) begin
                tick($urandom_range(0, 99) != 0,
                     $urandom_range(0, 7) == 0,
                     $urandom_range(0, 99) < pct,
                     $urandom_range(0, 5) == 0,
                     $urandom_range(0, 3) == 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
